uut_xfer_seq: RTL

//  Host-side sequencer for the uut burst-copy engine. Queues copy jobs (src, dst, len),

---
 rtl/uut_xfer_seq_pkg.sv | 36 +++
 rtl/uut_xfer_fifo.sv | 59 +++++
 rtl/uut_xfer_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uut_xfer_seq_pkg.sv
// Shared definitions for the uut burst-copy sequencer: FSM states, completion codes,
// CSR bit positions and the control-word builder.
package uut_xfer_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_CHK,
        S_SRC_BASE,
        S_RD_GO,
        S_RD_POLL,
        S_DST_BASE,
        S_WR_GO,
        S_WR_POLL,
        S_CLR,
        S_DONE
    } state_t;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_LEN0 = 2'b01;
    localparam logic [1:0] ST_ERR  = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;

    localparam int CTRL_STARTWR = 16;
    localparam int CTRL_STARTRD = 17;
    localparam int CTRL_CLRERR  = 18;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_ERROR   = 1;

    localparam int JOB_W = 76;

    // Control word: length field plus exactly one command bit.
    function automatic logic [31:0] ctrl_word(input logic [11:0] len, input int bitpos);
        return 32'(len) | (32'd1 << bitpos);
    endfunction

endpackage

// File: rtl/uut_xfer_fifo.sv
// Synchronous job FIFO with separate occupancy count; simultaneous push and pop
// is accepted even when full.
module uut_xfer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 76
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uut_xfer_seq.sv
// Host-side sequencer: queues copy jobs, programs the uut CSR port for a read burst
// then a write burst, polls status and reports one completion per job.
module uut_xfer_seq
    import uut_xfer_seq_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter int                CSR_AW     = 5,
    parameter int                RD_LAT     = 1,
    parameter logic [CSR_AW-1:0] ADDR_BASE  = CSR_AW'('h1),
    parameter logic [CSR_AW-1:0] ADDR_CTRL  = CSR_AW'('h0),
    parameter logic [CSR_AW-1:0] ADDR_STAT  = CSR_AW'('h2),
    parameter int                POLL_TMO   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_src,
    input  logic [31:0]       cmd_dst,
    input  logic [11:0]       cmd_len,
    output logic              done_valid,
    output logic [1:0]        done_status,
    output logic              idle,
    output logic [CSR_AW-1:0] csr_address,
    output logic              csr_write,
    output logic [31:0]       csr_writedata,
    output logic              csr_read,
    input  logic [31:0]       csr_readdata
);

    localparam int PCW = $clog2(POLL_TMO + 1);

    state_t             state_reg, state_next;
    logic [31:0]        src_reg, dst_reg;
    logic [11:0]        len_reg;
    logic [1:0]         code_reg, code_next;
    logic [1:0]         done_status_reg;
    logic [PCW-1:0]     poll_cnt_reg;
    logic [RD_LAT-1:0]  lat_reg, lat_next;
    logic               fifo_full, fifo_empty, pop;
    logic [JOB_W-1:0]   fifo_out;
    logic               in_poll, rd_issue, sample, stat_busy, stat_err, timeout;
    logic               unused_rd;

    uut_xfer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (JOB_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid && cmd_ready),
        .wr_data ({cmd_src, cmd_dst, cmd_len}),
        .pop     (pop),
        .rd_data (fifo_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd_ready   = !fifo_full;
    assign idle        = fifo_empty && (state_reg == S_IDLE);
    assign done_status = done_status_reg;

    // One status read in flight at a time; readdata is sampled when the strobe
    // reaches the last tap, and the next read goes out the cycle after.
    assign in_poll   = (state_reg == S_RD_POLL) || (state_reg == S_WR_POLL);
    assign rd_issue  = in_poll && (lat_reg == '0);
    assign sample    = lat_reg[RD_LAT-1];
    assign stat_busy = csr_readdata[STAT_BUSY];
    assign stat_err  = csr_readdata[STAT_ERROR];
    assign timeout   = (poll_cnt_reg == PCW'(POLL_TMO - 1));
    assign csr_read  = rd_issue;
    assign unused_rd = ^csr_readdata[31:2];

    assign lat_next[0] = rd_issue;
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_lat
        assign lat_next[gi] = lat_reg[gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            src_reg         <= '0;
            dst_reg         <= '0;
            len_reg         <= '0;
            code_reg        <= ST_OK;
            done_status_reg <= ST_OK;
            poll_cnt_reg    <= '0;
            lat_reg         <= '0;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            lat_reg   <= lat_next;
            if (pop) begin
                {src_reg, dst_reg, len_reg} <= fifo_out;
            end
            if (state_next == S_DONE) begin
                done_status_reg <= code_next;
            end
            if (!in_poll) begin
                poll_cnt_reg <= '0;
            end else if (sample && stat_busy) begin
                poll_cnt_reg <= poll_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        code_next     = code_reg;
        pop           = 1'b0;
        csr_write     = 1'b0;
        csr_address   = '0;
        csr_writedata = '0;
        done_valid    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_LEN_CHK;
                end
            end
            S_LEN_CHK: begin
                // A zero-length burst would hang the engine, so it never reaches the CSRs.
                if (len_reg == '0) begin
                    code_next  = ST_LEN0;
                    state_next = S_DONE;
                end else begin
                    state_next = S_SRC_BASE;
                end
            end
            S_SRC_BASE: begin
                csr_write     = 1'b1;
                csr_address   = ADDR_BASE;
                csr_writedata = src_reg;
                state_next    = S_RD_GO;
            end
            S_RD_GO: begin
                csr_write     = 1'b1;
                csr_address   = ADDR_CTRL;
                csr_writedata = ctrl_word(len_reg, CTRL_STARTRD);
                state_next    = S_RD_POLL;
            end
            S_RD_POLL: begin
                csr_address = ADDR_STAT;
                if (sample) begin
                    if (stat_err) begin
                        code_next  = ST_ERR;
                        state_next = S_CLR;
                    end else if (!stat_busy) begin
                        state_next = S_DST_BASE;
                    end else if (timeout) begin
                        code_next  = ST_TMO;
                        state_next = S_CLR;
                    end
                end
            end
            S_DST_BASE: begin
                csr_write     = 1'b1;
                csr_address   = ADDR_BASE;
                csr_writedata = dst_reg;
                state_next    = S_WR_GO;
            end
            S_WR_GO: begin
                csr_write     = 1'b1;
                csr_address   = ADDR_CTRL;
                csr_writedata = ctrl_word(len_reg, CTRL_STARTWR);
                state_next    = S_WR_POLL;
            end
            S_WR_POLL: begin
                csr_address = ADDR_STAT;
                if (sample) begin
                    if (stat_err) begin
                        code_next  = ST_ERR;
                        state_next = S_CLR;
                    end else if (!stat_busy) begin
                        code_next  = ST_OK;
                        state_next = S_DONE;
                    end else if (timeout) begin
                        code_next  = ST_TMO;
                        state_next = S_CLR;
                    end
                end
            end
            S_CLR: begin
                csr_write     = 1'b1;
                csr_address   = ADDR_CTRL;
                csr_writedata = ctrl_word(len_reg, CTRL_CLRERR);
                state_next    = S_DONE;
            end
            S_DONE: begin
                done_valid = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Address only matters while a strobe is out; keep it quiet otherwise.
        if (!csr_write && !rd_issue) begin
            csr_address = '0;
        end
    end

endmodule
